// File: rtl/sfp_frame_rx.sv
// sfp_frame_rx: NRZ serial receiver (start, LSB-first data, even parity, stop) with link and error status.
// Optional: define SFP_RX_GLITCH_FILTER_EN for a 3-tap majority filter behind the synchronizer.
module sfp_frame_rx #(
    parameter int OVERSAMPLE   = 4,
    parameter int DATA_W       = 8,
    parameter int LINK_TIMEOUT = 1000
) (
    input  logic              i_clk,
    input  logic              i_res_n,
    input  logic              i_rxd,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_link_up,
    output logic [7:0]        o_err_cnt
);
    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = $clog2(LINK_TIMEOUT + 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
    localparam logic [TW-1:0] TMAX = TW'(LINK_TIMEOUT);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, BREAK = 3'd5;

    logic              s1, s2, rxd, rxd_p;
    logic [2:0]        state;
    logic [CW-1:0]     phase;
    logic [BW-1:0]     idx;
    logic [DATA_W-1:0] shift;
    logic              par;
    logic [TW-1:0]     timer;
    logic              tick, stop_t, good, bad;

`ifdef SFP_RX_GLITCH_FILTER_EN
    logic t1, t2;
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            t1 <= 1'b1;
            t2 <= 1'b1;
        end else begin
            t1 <= s2;
            t2 <= t1;
        end
    end
    assign rxd = (s2 & t1) | (s2 & t2) | (t1 & t2);
`else
    assign rxd = s2;
`endif

    // START samples mid-bit; later bits are one full bit period apart.
    assign tick   = phase == ((state == START) ? HALF : FULL);
    assign stop_t = (state == STOP) && tick;
    assign good   = stop_t && rxd && !par;
    assign bad    = stop_t && (!rxd || par);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            rxd_p        <= 1'b1;
            state        <= IDLE;
            phase        <= '0;
            idx          <= '0;
            shift        <= '0;
            par          <= 1'b0;
            timer        <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_link_up    <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            s1           <= i_rxd;
            s2           <= s1;
            rxd_p        <= rxd;
            phase        <= tick ? CW'(1) : phase + 1'b1;
            o_valid      <= good;
            o_parity_err <= stop_t && rxd && par;
            o_frame_err  <= stop_t && !rxd;
            o_data       <= good ? shift : o_data;
            case (state)
                IDLE: begin
                    phase <= CW'(1);
                    idx   <= '0;
                    state <= (!rxd && rxd_p) ? START : IDLE;
                end
                START:  state <= tick ? (rxd ? IDLE : DATA) : START;
                DATA: if (tick) begin
                    shift <= {rxd, shift[DATA_W-1:1]};
                    idx   <= idx + 1'b1;
                    state <= (idx == LAST) ? PARITY : DATA;
                end
                PARITY: if (tick) begin
                    par   <= ^shift ^ rxd;
                    state <= STOP;
                end
                STOP:   state <= tick ? (rxd ? IDLE : BREAK) : STOP;
                BREAK:  state <= rxd ? IDLE : BREAK;
                default: state <= IDLE;
            endcase
            timer     <= good ? TMAX : (timer != '0) ? timer - 1'b1 : timer;
            o_link_up <= good ? 1'b1 : (bad || timer == TW'(1)) ? 1'b0 : o_link_up;
            // Counter follows the visible pulse so a clear during the pulse leaves 1.
            o_err_cnt <= i_err_clr ? {7'd0, o_parity_err | o_frame_err} :
                         ((o_parity_err | o_frame_err) && o_err_cnt != 8'hFF) ? o_err_cnt + 8'd1 : o_err_cnt;
        end
    end
endmodule
